// File: rtl/fifo_push_arbiter.sv
// Round-robin push arbiter with burst locking in front of a shared FIFO.
// Tracks FIFO occupancy to gate pops and to provide empty/count.
module fifo_push_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 2,
    parameter int DEPTH = 4,
    parameter int BURST = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]         gnt,
    input  logic                     cons_pop,
    output logic [WIDTH-1:0]         fifo_in,
    output logic                     fifo_push,
    output logic                     fifo_pop,
    input  logic                     fifo_full,
    output logic                     empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = $clog2(BURST + 1);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] rr_ptr_q, rr_ptr_d;
    logic [PW-1:0] owner_q, owner_d;
    logic [BW-1:0] burst_cnt_q, burst_cnt_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty_q, empty_d;

    logic          push_ok;
    logic          owner_req;
    logic          search_hit;
    logic [PW-1:0] search_idx;
    logic          grant_vld;
    logic [PW-1:0] grant_idx;
    logic          push_only;
    logic          pop_only;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] i);
        return (int'(i) == N_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    // First requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        int idx;
        idx        = 0;
        search_hit = 1'b0;
        search_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % N_REQ;
            if (!search_hit && req[PW'(idx)]) begin
                search_hit = 1'b1;
                search_idx = PW'(idx);
            end
        end
    end

    always_comb begin
        fifo_pop  = cons_pop && !empty_q && !reset;
        push_ok   = !fifo_full || fifo_pop;
        owner_req = (state_q == LOCK) && req[owner_q];
        grant_vld = push_ok && (owner_req || search_hit) && !reset;
        grant_idx = owner_req ? owner_q : search_idx;
        gnt       = grant_vld ? (N_REQ'(1) << grant_idx) : '0;
        fifo_push = grant_vld;
        fifo_in   = grant_vld ?
                    req_data[int'(grant_idx)*WIDTH +: WIDTH] : '0;
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        if (push_ok) begin
            if (owner_req) begin
                if (int'(burst_cnt_q) + 1 >= BURST) begin
                    state_d     = IDLE;
                    rr_ptr_d    = wrap_inc(owner_q);
                    burst_cnt_d = '0;
                end else begin
                    burst_cnt_d = burst_cnt_q + 1'b1;
                end
            end else begin
                // Owner dropped req: release, then treat as IDLE.
                if (state_q == LOCK) begin
                    state_d     = IDLE;
                    rr_ptr_d    = wrap_inc(owner_q);
                    burst_cnt_d = '0;
                end
                if (grant_vld) begin
                    if (BURST > 1) begin
                        state_d     = LOCK;
                        owner_d     = grant_idx;
                        burst_cnt_d = BW'(1);
                    end else begin
                        rr_ptr_d = wrap_inc(grant_idx);
                    end
                end
            end
        end
    end

    always_comb begin
        push_only = fifo_push && !fifo_pop;
        pop_only  = fifo_pop && !fifo_push;
        count_d   = count_q;
        if (push_only && count_q < CW'(DEPTH)) begin
            count_d = count_q + 1'b1;
        end else if (pop_only && count_q != '0) begin
            count_d = count_q - 1'b1;
        end
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            burst_cnt_q <= '0;
            count_q     <= '0;
            empty_q     <= 1'b1;
        end else begin
            assert (!(push_only && count_q == CW'(DEPTH)));
            assert (!(pop_only && count_q == '0));
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            count_q     <= count_d;
            empty_q     <= empty_d;
        end
    end

    assign empty = empty_q;
    assign count = count_q;

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Scoreboard bench for fifo_push_arbiter with a queue-based FIFO
// and a high-level arbitration model.
module tb_fifo_push_arbiter;

    localparam int N = 4;
    localparam int W = 2;
    localparam int D = 4;
    localparam int B = 2;

    logic           clk;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   gnt;
    logic           cons_pop;
    logic [W-1:0]   fifo_in;
    logic           fifo_push;
    logic           fifo_pop;
    logic           fifo_full = 1'b0;
    logic           empty;
    logic [2:0]     count;

    fifo_push_arbiter #(
        .N_REQ(N), .WIDTH(W), .DEPTH(D), .BURST(B)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .gnt(gnt), .cons_pop(cons_pop), .fifo_in(fifo_in),
        .fifo_push(fifo_push), .fifo_pop(fifo_pop),
        .fifo_full(fifo_full), .empty(empty), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the shared FIFO.
    logic [W-1:0] fq[$];
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            fq.delete();
            fifo_full <= 1'b0;
        end else begin
            if (fifo_pop && fq.size() > 0) void'(fq.pop_front());
            if (fifo_push && fq.size() < D) fq.push_back(fifo_in);
            fifo_full <= (fq.size() == D);
        end
    end

    typedef struct {
        int gnt;
        int din;
        int pop;
        int cnt;
        int emp;
    } exp_t;
    exp_t expq[$];

    int pass_cnt = 0;
    int total = 0;

    int rr = 0;
    int owner = -1;
    int run = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            while (expq.size() > 0) begin
                e = expq.pop_front();
                chk("gnt", int'(gnt), e.gnt);
                chk("fifo_push", int'(fifo_push), (e.gnt != 0) ? 1 : 0);
                chk("fifo_in", int'(fifo_in), e.din);
                chk("fifo_pop", int'(fifo_pop), e.pop);
                chk("count", int'(count), e.cnt);
                chk("empty", int'(empty), e.emp);
            end
        end
    end

    task automatic step(input logic [N-1:0] r, input logic [N*W-1:0] d,
                        input logic p, output int g);
        exp_t e;
        int sz;
        bit popx;
        bit ok;
        @(negedge clk);
        req = r;
        req_data = d;
        cons_pop = p;
        #1;
        sz = fq.size();
        popx = p && (sz > 0);
        ok = (sz != D) || popx;
        g = -1;
        if (ok) begin
            if (owner >= 0 && r[owner]) g = owner;
            else
                for (int k = 0; k < N; k++)
                    if (g < 0 && r[(rr + k) % N]) g = (rr + k) % N;
        end
        e.gnt = (g >= 0) ? (1 << g) : 0;
        e.din = (g >= 0) ? int'(d[g*W +: W]) : 0;
        e.pop = popx ? 1 : 0;
        e.cnt = sz;
        e.emp = (sz == 0) ? 1 : 0;
        expq.push_back(e);
        if (ok) begin
            if (owner >= 0 && g == owner) begin
                run++;
                if (run >= B) begin
                    owner = -1;
                    rr = (g + 1) % N;
                end
            end else begin
                if (owner >= 0) begin
                    rr = (owner + 1) % N;
                    owner = -1;
                end
                if (g >= 0) begin
                    if (B > 1) begin
                        owner = g;
                        run = 1;
                    end else begin
                        rr = (g + 1) % N;
                    end
                end
            end
        end
    endtask

    task automatic do_reset(input logic [N-1:0] r);
        @(negedge clk);
        #3;
        reset = 1'b1;
        req = r;
        cons_pop = 1'b1;
        #1;
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_push", int'(fifo_push), 0);
        chk("rst_pop", int'(fifo_pop), 0);
        chk("rst_in", int'(fifo_in), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        rr = 0;
        owner = -1;
        run = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        req = '0;
        cons_pop = 1'b0;
    endtask

    initial begin
        logic [N*W-1:0] d;
        logic [N-1:0]   rq;
        logic [N*W-1:0] rd;
        int g;
        int npop;
        int t2 [4];
        t2 = '{0, 0, 1, 1};
        reset = 1'b1;
        req = '0;
        req_data = '0;
        cons_pop = 1'b0;
        d = 8'b11_10_01_00;

        do_reset('0);

        step('0, d, 1'b1, g);
        chk("t1_pop_empty", int'(fifo_pop), 0);

        for (int i = 0; i < 4; i++) begin
            step(4'b1111, d, 1'b0, g);
            chk("t2_grant", int'(gnt), 1 << t2[i]);
        end
        step(4'b1111, d, 1'b0, g);
        chk("t2_full_gnt", int'(gnt), 0);
        chk("t2_count", int'(count), 4);

        step(4'b0100, d, 1'b1, g);
        chk("t3_gnt", int'(gnt), 4'b0100);
        chk("t3_pop", int'(fifo_pop), 1);

        step(4'b0010, d, 1'b1, g);
        chk("t4_gnt1", int'(gnt), 4'b0010);
        chk("t3_count", int'(count), 4);
        step(4'b1000, d, 1'b1, g);
        chk("t4_gnt3", int'(gnt), 4'b1000);
        step(4'b0000, d, 1'b1, g);
        step(4'b1111, d, 1'b1, g);
        chk("t4_rr0", int'(gnt), 4'b0001);
        step(4'b0001, d, 1'b0, g);

        npop = 0;
        for (int i = 0; i < 5; i++) begin
            step('0, d, 1'b1, g);
            npop += int'(fifo_pop);
        end
        chk("t5_pops", npop, 4);
        chk("t5_empty", int'(empty), 1);

        step(4'b0001, d, 1'b0, g);
        step(4'b0001, d, 1'b0, g);
        step(4'b0010, d, 1'b0, g);
        @(negedge clk);
        #3;
        chk("t6_pre_count", int'(count), 3);
        do_reset(4'b1010);
        step(4'b1010, d, 1'b0, g);
        chk("t6_first", int'(gnt), 4'b0010);

        rq = '0;
        rd = '0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!rq[i] && $urandom_range(99) < 40) begin
                    rq[i] = 1'b1;
                    rd[i*W +: W] = W'($urandom);
                end
            end
            step(rq, rd, 1'($urandom_range(99) < 45), g);
            if (g >= 0) begin
                if ($urandom_range(1) == 1) rd[g*W +: W] = W'($urandom);
                else rq[g] = 1'b0;
            end
            if ($urandom_range(199) == 0) begin
                do_reset(rq);
                rq = '0;
            end
        end

        @(negedge clk);
        #3;
        chk("queue_drained", expq.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
